seg_scan_ctrl: RTL

//   Parametrised, clocked multiplexed 7-segment digit scanner; successor to the fixed 4-digit anode decode.
//   - Owns the refresh timing.
//   - Rotates the active digit through NUM_DIGITS positions.
//   - Applies per-digit blanking and 16-level PWM brightness.
//   - Exports the digit index so the segment mux / hex decoder selects matching data.
//   - Sits between the top-level value registers and the board anode/segment pins.

---
 rtl/seg_scan_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment digit scanner with per-digit blanking and 16-level PWM.
// Outputs are registered and lag the internal scan counters by one clock.
module seg_scan_ctrl #(
  parameter int  NUM_DIGITS = 4,
  parameter int  PHASE_LEN  = 3125,
  parameter bit  ACTIVE_LOW = 1'b1,
  localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  input  logic [3:0]            brightness,
  output logic [IDX_W-1:0]      digit_sel,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  frame_tick
);

  localparam int SUB_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

  logic [SUB_W-1:0]      sub_q, sub_d;
  logic [3:0]            phase_q, phase_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] blank_sh_q, blank_sh_d;
  logic [3:0]            bright_sh_q, bright_sh_d;
  logic [IDX_W-1:0]      digit_sel_q, digit_sel_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0] on_vec;
  logic                  slot_start;
  logic                  sub_last;

  // Next-state for counters and shadows, plus the registered output values
  always_comb begin
    sub_d        = sub_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    blank_sh_d   = blank_sh_q;
    bright_sh_d  = bright_sh_q;
    digit_sel_d  = digit_sel_q;
    frame_tick_d = 1'b0;
    on_vec       = {NUM_DIGITS{1'b0}};
    slot_start   = (sub_q == {SUB_W{1'b0}}) && (phase_q == 4'd0);
    sub_last     = (sub_q == SUB_W'(PHASE_LEN - 1));

    if (en) begin
      // Shadows load on slot entry and feed this cycle's anode decision directly,
      // so the first clock of a slot already uses the freshly sampled values.
      if (slot_start) begin
        blank_sh_d  = blank_mask;
        bright_sh_d = brightness;
      end else begin
        blank_sh_d  = blank_sh_q;
        bright_sh_d = bright_sh_q;
      end

      if (sub_last) begin
        sub_d   = {SUB_W{1'b0}};
        phase_d = phase_q + 4'd1;
        if (phase_q == 4'd15) begin
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d = {IDX_W{1'b0}};
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end else begin
        sub_d   = sub_q + SUB_W'(1);
        phase_d = phase_q;
        idx_d   = idx_q;
      end

      for (int i = 0; i < NUM_DIGITS; i++) begin
        on_vec[i] = (idx_q == IDX_W'(i)) && !blank_sh_d[i] && (phase_q < bright_sh_d);
      end

      digit_sel_d  = idx_q;
      frame_tick_d = (digit_sel_q == IDX_W'(NUM_DIGITS - 1)) && (idx_q == {IDX_W{1'b0}});
    end else begin
      digit_sel_d  = digit_sel_q;
      frame_tick_d = 1'b0;
    end

    if (ACTIVE_LOW) begin
      anode_d = ~on_vec;
    end else begin
      anode_d = on_vec;
    end
  end

  // State and output registers; reset parks the scan dark at digit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q        <= {SUB_W{1'b0}};
      phase_q      <= 4'd0;
      idx_q        <= {IDX_W{1'b0}};
      blank_sh_q   <= {NUM_DIGITS{1'b1}};
      bright_sh_q  <= 4'd0;
      digit_sel_q  <= {IDX_W{1'b0}};
      anode_q      <= {NUM_DIGITS{ACTIVE_LOW}};
      frame_tick_q <= 1'b0;
    end else begin
      sub_q        <= sub_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      blank_sh_q   <= blank_sh_d;
      bright_sh_q  <= bright_sh_d;
      digit_sel_q  <= digit_sel_d;
      anode_q      <= anode_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign digit_sel  = digit_sel_q;
  assign anode      = anode_q;
  assign frame_tick = frame_tick_q;

endmodule
